// File: rtl/cpu7_ifu_fbuf.sv
// rtl/cpu7_ifu_fbuf.sv - in-order instruction fetch buffer between imem and decode
//
// Entries are reserved (with their PC) when a fetch request is accepted and
// filled when the matching response returns; decode sees them strictly in order.
// A redirect (flush) empties the buffer and arranges for every response still in
// flight for the old path to be discarded as it arrives.
//
// Ports:
//   clock, resetn                    core clock, asynchronous active-low reset
//   req_fire, req_pc                 accepted fetch request and its address
//   fbuf_credit                      an entry is free, fetch may issue
//   rsp_valid, rsp_inst,
//   rsp_ex, rsp_exccode              fetch response with optional exception
//   flush                            redirect, drops buffered and in-flight work
//   deq_ready                        decode accepts the head entry
//   fbuf_dec_valid/inst/pc/ex/exccode  head entry presented to decode
//   fbuf_err                         sticky protocol-violation flag

`ifndef GRLEN
`define GRLEN 32
`endif

module cpu7_ifu_fbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_fire,
  input  logic [31:0]       req_pc,
  output logic              fbuf_credit,
  input  logic              rsp_valid,
  input  logic [31:0]       rsp_inst,
  input  logic              rsp_ex,
  input  logic [5:0]        rsp_exccode,
  input  logic              flush,
  input  logic              deq_ready,
  output logic              fbuf_dec_valid,
  output logic [31:0]       fbuf_dec_inst,
  output logic [`GRLEN-1:0] fbuf_dec_pc,
  output logic              fbuf_dec_ex,
  output logic [5:0]        fbuf_dec_exccode,
  output logic              fbuf_err
);

  localparam int CW = AW + 1;
  localparam int KW = AW + 3;

  logic [AW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [AW-1:0] fill_ptr_q, fill_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] alloc_cnt_q, alloc_cnt_d;
  logic [CW-1:0] kill_cnt_q, kill_cnt_d;
  logic          err_q, err_d;

  logic [31:0]      pc_q      [DEPTH];
  logic [31:0]      pc_d      [DEPTH];
  logic [31:0]      inst_q    [DEPTH];
  logic [31:0]      inst_d    [DEPTH];
  logic             ex_q      [DEPTH];
  logic             ex_d      [DEPTH];
  logic [5:0]       exccode_q [DEPTH];
  logic [5:0]       exccode_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;

  logic [CW-1:0] filled_cnt;
  logic [CW-1:0] unfilled_cnt;
  logic          credit;
  logic          head_valid;
  logic          deq;
  logic          do_alloc;
  logic          rsp_live;
  logic          do_drop;
  logic          do_fill;
  logic          rsp_orphan;
  logic [KW-1:0] kill_sum;
  logic [KW-1:0] kill_new;

  // Filled bits are cleared on dequeue, so their population count is exactly
  // the number of allocated entries that already hold their instruction.
  always_comb begin
    filled_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      filled_cnt = filled_cnt + CW'(filled_q[i]);
    end
  end

  // Counting unfilled entries (instead of comparing fill/alloc pointers) keeps a
  // full buffer of outstanding requests distinguishable from an idle one.
  assign unfilled_cnt = alloc_cnt_q - filled_cnt;
  assign credit       = (alloc_cnt_q < CW'(DEPTH));
  assign head_valid   = filled_q[rd_ptr_q] & (alloc_cnt_q != '0) & ~flush;
  assign deq          = head_valid & deq_ready;
  assign do_alloc     = req_fire & ~flush & credit;
  assign rsp_live     = rsp_valid & ~flush;
  assign do_drop      = rsp_live & (kill_cnt_q != '0);
  assign do_fill      = rsp_live & (kill_cnt_q == '0) & (unfilled_cnt != '0);
  assign rsp_orphan   = rsp_live & (kill_cnt_q == '0) & (unfilled_cnt == '0);

  // Stale responses after a redirect: those already owed, the unfilled entries
  // being thrown away and a request accepted in the flush cycle itself, minus a
  // response arriving in that same cycle. Widened to avoid wrap, clamped to CW.
  always_comb begin
    kill_sum = KW'(kill_cnt_q) + KW'(unfilled_cnt) + KW'(req_fire);
    if (kill_sum < KW'(rsp_valid)) begin
      kill_new = '0;
    end else begin
      kill_new = kill_sum - KW'(rsp_valid);
    end
    if (kill_new > KW'({CW{1'b1}})) begin
      kill_new = KW'({CW{1'b1}});
    end
  end

  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    alloc_cnt_d = alloc_cnt_q;
    kill_cnt_d  = kill_cnt_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    ex_d        = ex_q;
    exccode_d   = exccode_q;
    filled_d    = filled_q;
    err_d       = err_q | (req_fire & ~flush & ~credit) | rsp_orphan;

    if (flush) begin
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      rd_ptr_d    = '0;
      alloc_cnt_d = '0;
      filled_d    = '0;
      kill_cnt_d  = kill_new[CW-1:0];
    end else begin
      if (do_drop) begin
        kill_cnt_d = kill_cnt_q - CW'(1);
      end
      if (do_fill) begin
        inst_d[fill_ptr_q]    = rsp_inst;
        ex_d[fill_ptr_q]      = rsp_ex;
        exccode_d[fill_ptr_q] = rsp_exccode;
        filled_d[fill_ptr_q]  = 1'b1;
        fill_ptr_d            = fill_ptr_q + AW'(1);
      end
      if (deq) begin
        filled_d[rd_ptr_q] = 1'b0;
        rd_ptr_d           = rd_ptr_q + AW'(1);
      end
      // A free slot never aliases the head or the fill target, so the
      // order of these writes does not matter.
      if (do_alloc) begin
        pc_d[alloc_ptr_q]     = req_pc;
        filled_d[alloc_ptr_q] = 1'b0;
        alloc_ptr_d           = alloc_ptr_q + AW'(1);
      end
      alloc_cnt_d = alloc_cnt_q + CW'(do_alloc) - CW'(deq);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      alloc_cnt_q <= '0;
      kill_cnt_q  <= '0;
      err_q       <= 1'b0;
      filled_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]      <= '0;
        inst_q[i]    <= '0;
        ex_q[i]      <= 1'b0;
        exccode_q[i] <= '0;
      end
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      alloc_cnt_q <= alloc_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
      err_q       <= err_d;
      filled_q    <= filled_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      ex_q        <= ex_d;
      exccode_q   <= exccode_d;
    end
  end

  assign fbuf_credit      = credit;
  assign fbuf_dec_valid   = head_valid;
  assign fbuf_dec_inst    = inst_q[rd_ptr_q];
  assign fbuf_dec_pc      = `GRLEN'(pc_q[rd_ptr_q]);
  assign fbuf_dec_ex      = ex_q[rd_ptr_q];
  assign fbuf_dec_exccode = exccode_q[rd_ptr_q];
  assign fbuf_err         = err_q;

endmodule

// File: tb/tb_cpu7_ifu_fbuf.sv
// tb/tb_cpu7_ifu_fbuf.sv - self-checking bench for cpu7_ifu_fbuf
//
// Ports: none (top-level bench). Drives the fetch buffer with directed
// sequences and compares it every cycle against a queue-based model.

`ifndef GRLEN
`define GRLEN 32
`endif

module tb_cpu7_ifu_fbuf;

  logic              clock;
  logic              resetn;
  logic              req_fire;
  logic [31:0]       req_pc;
  logic              fbuf_credit;
  logic              rsp_valid;
  logic [31:0]       rsp_inst;
  logic              rsp_ex;
  logic [5:0]        rsp_exccode;
  logic              flush;
  logic              deq_ready;
  logic              fbuf_dec_valid;
  logic [31:0]       fbuf_dec_inst;
  logic [`GRLEN-1:0] fbuf_dec_pc;
  logic              fbuf_dec_ex;
  logic [5:0]        fbuf_dec_exccode;
  logic              fbuf_err;

  cpu7_ifu_fbuf #(.DEPTH(4), .AW(2)) dut (
    .clock           (clock),
    .resetn          (resetn),
    .req_fire        (req_fire),
    .req_pc          (req_pc),
    .fbuf_credit     (fbuf_credit),
    .rsp_valid       (rsp_valid),
    .rsp_inst        (rsp_inst),
    .rsp_ex          (rsp_ex),
    .rsp_exccode     (rsp_exccode),
    .flush           (flush),
    .deq_ready       (deq_ready),
    .fbuf_dec_valid  (fbuf_dec_valid),
    .fbuf_dec_inst   (fbuf_dec_inst),
    .fbuf_dec_pc     (fbuf_dec_pc),
    .fbuf_dec_ex     (fbuf_dec_ex),
    .fbuf_dec_exccode(fbuf_dec_exccode),
    .fbuf_err        (fbuf_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the buffer is an ordered list of reserved entries, plus a count of
  // responses owed to the abandoned path.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
    logic [5:0]  code;
    bit          filled;
  } ent_t;

  ent_t mq[$];
  int   mkill;
  bit   merr;

  function automatic int m_unfilled();
    int n = 0;
    foreach (mq[i]) if (!mq[i].filled) n++;
    return n;
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      mkill = 0;
      merr  = 0;
    end else if (flush) begin
      mkill = mkill + m_unfilled() + int'(req_fire) - int'(rsp_valid);
      if (mkill < 0) mkill = 0;
      mq.delete();
    end else begin
      int   sz0;
      int   fi;
      bit   dv;
      ent_t e;
      sz0 = mq.size();
      dv  = (sz0 > 0) && mq[0].filled;
      fi  = -1;
      for (int i = sz0 - 1; i >= 0; i--) if (!mq[i].filled) fi = i;
      if (rsp_valid) begin
        if (mkill > 0) mkill--;
        else if (fi >= 0) begin
          mq[fi].inst   = rsp_inst;
          mq[fi].ex     = rsp_ex;
          mq[fi].code   = rsp_exccode;
          mq[fi].filled = 1;
        end else merr = 1;
      end
      if (dv && deq_ready) void'(mq.pop_front());
      if (req_fire) begin
        if (sz0 < 4) begin
          e.pc = req_pc; e.inst = '0; e.ex = 0; e.code = '0; e.filled = 0;
          mq.push_back(e);
        end else merr = 1;
      end
    end
  end

  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];
  bit          low_credit_seen;

  always @(negedge clock) begin
    bit exp_v;
    exp_v = (mq.size() > 0) && mq[0].filled && !flush;
    check("credit", 64'(fbuf_credit), 64'(mq.size() < 4));
    check("dec_valid", 64'(fbuf_dec_valid), 64'(exp_v));
    check("err", 64'(fbuf_err), 64'(merr));
    if (exp_v && fbuf_dec_valid) begin
      check("dec_pc", 64'(fbuf_dec_pc), 64'(mq[0].pc));
      check("dec_inst", 64'(fbuf_dec_inst), 64'(mq[0].inst));
      check("dec_ex", 64'(fbuf_dec_ex), 64'(mq[0].ex));
      check("dec_exccode", 64'(fbuf_dec_exccode), 64'(mq[0].code));
    end
    if (resetn && fbuf_dec_valid && deq_ready) begin
      got_pc.push_back(fbuf_dec_pc[31:0]);
      got_inst.push_back(fbuf_dec_inst);
    end
    if (!fbuf_credit) low_credit_seen = 1;
  end

  task automatic drive(input bit rf, input logic [31:0] pc, input bit rv, input logic [31:0] inst,
                       input bit fl, input bit dr, input bit ex = 1'b0, input logic [5:0] code = 6'd0);
    req_fire = rf; req_pc = pc; rsp_valid = rv; rsp_inst = inst;
    rsp_ex = ex; rsp_exccode = code; flush = fl; deq_ready = dr;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cyc(input bit rf, input logic [31:0] pc, input bit rv, input logic [31:0] inst,
                     input bit fl, input bit dr, input bit ex = 1'b0, input logic [5:0] code = 6'd0);
    drive(rf, pc, rv, inst, fl, dr, ex, code);
    step();
  endtask

  initial begin
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    low_credit_seen = 0;
    repeat (2) step();

    // Reset state
    check("rst_credit", 64'(fbuf_credit), 64'd1);
    check("rst_valid", 64'(fbuf_dec_valid), 64'd0);
    check("rst_pc", 64'(fbuf_dec_pc), 64'd0);
    check("rst_inst", 64'(fbuf_dec_inst), 64'd0);
    check("rst_ex", 64'(fbuf_dec_ex), 64'd0);
    check("rst_exccode", 64'(fbuf_dec_exccode), 64'd0);
    check("rst_err", 64'(fbuf_err), 64'd0);
    resetn = 1'b1;
    step();

    // In-order stream, responses one cycle behind requests
    got_pc.delete(); got_inst.delete(); low_credit_seen = 0;
    cyc(1, 32'h1c000000, 0, 32'h0, 0, 1);
    cyc(1, 32'h1c000004, 1, 32'h02800000, 0, 1);
    cyc(1, 32'h1c000008, 1, 32'h02800001, 0, 1);
    cyc(1, 32'h1c00000c, 1, 32'h02800002, 0, 1, 1'b1, 6'h08);
    cyc(0, 32'h0,        1, 32'h02800003, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    check("stream_count", 64'(got_pc.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_pc.size(); i++) begin
      check("stream_pc", 64'(got_pc[i]), 64'(32'h1c000000 + 32'(4 * i)));
      check("stream_inst", 64'(got_inst[i]), 64'(32'h02800000 + 32'(i)));
    end
    check("stream_credit_low", 64'(low_credit_seen), 64'd0);

    // Flush with one filled and two unfilled entries
    got_pc.delete(); got_inst.delete();
    cyc(1, 32'h1c000040, 0, 32'h0, 0, 0);
    cyc(1, 32'h1c000044, 1, 32'h0a000000, 0, 0);
    cyc(1, 32'h1c000048, 0, 32'h0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("pre_flush_valid", 64'(fbuf_dec_valid), 64'd1);
    cyc(0, 0, 0, 0, 1, 1);
    drive(1, 32'h1c000100, 0, 0, 0, 1);
    #1;
    check("post_flush_valid", 64'(fbuf_dec_valid), 64'd0);
    step();
    cyc(0, 0, 1, 32'hdead0001, 0, 1);
    cyc(0, 0, 1, 32'hdead0002, 0, 1);
    cyc(0, 0, 1, 32'h0b000000, 0, 1);
    repeat (2) cyc(0, 0, 0, 0, 0, 1);
    check("flush_count", 64'(got_pc.size()), 64'd1);
    if (got_pc.size() > 0) begin
      check("flush_pc", 64'(got_pc[0]), 64'h1c000100);
      check("flush_inst", 64'(got_inst[0]), 64'h0b000000);
    end

    // Flush, request and response all in the same cycle
    got_pc.delete(); got_inst.delete();
    cyc(1, 32'h1c000080, 0, 32'h0, 0, 1);
    cyc(1, 32'h1c000084, 1, 32'hdead0003, 1, 1);
    cyc(1, 32'h1c000090, 0, 32'h0, 0, 1);
    cyc(0, 0, 1, 32'hdead0004, 0, 1);
    cyc(0, 0, 1, 32'h0c000000, 0, 1);
    repeat (2) cyc(0, 0, 0, 0, 0, 1);
    check("same_cycle_count", 64'(got_pc.size()), 64'd1);
    if (got_pc.size() > 0) begin
      check("same_cycle_pc", 64'(got_pc[0]), 64'h1c000090);
      check("same_cycle_inst", 64'(got_inst[0]), 64'h0c000000);
    end

    // Full buffer and overflow request
    for (int i = 0; i < 4; i++) cyc(1, 32'h1c000200 + 32'(4 * i), 0, 0, 0, 0);
    check("full_credit", 64'(fbuf_credit), 64'd0);
    check("full_err_before", 64'(fbuf_err), 64'd0);
    cyc(1, 32'h1c000210, 0, 0, 0, 0);
    check("overflow_err", 64'(fbuf_err), 64'd1);
    check("overflow_credit", 64'(fbuf_credit), 64'd0);
    cyc(0, 0, 1, 32'h0d000000, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("full_head_valid", 64'(fbuf_dec_valid), 64'd1);
    check("full_head_pc", 64'(fbuf_dec_pc), 64'h1c000200);
    check("full_head_inst", 64'(fbuf_dec_inst), 64'h0d000000);

    // Asynchronous reset mid-stream
    #2;
    resetn = 1'b0;
    #1;
    check("async_credit", 64'(fbuf_credit), 64'd1);
    check("async_valid", 64'(fbuf_dec_valid), 64'd0);
    check("async_err", 64'(fbuf_err), 64'd0);
    check("async_pc", 64'(fbuf_dec_pc), 64'd0);
    check("async_inst", 64'(fbuf_dec_inst), 64'd0);
    step();
    resetn = 1'b1;
    cyc(0, 0, 1, 32'h0e000000, 0, 0);
    check("orphan_err", 64'(fbuf_err), 64'd1);
    check("orphan_valid", 64'(fbuf_dec_valid), 64'd0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
